// File: rtl/qspi_pkg.sv
// qspi_pkg: opcodes, mode-byte match value, FSM states and defaults shared by the QSPI controller and responder
package qspi_pkg;
    localparam logic [7:0] CMD_FAST_READ_QUAD_IO = 8'hEB;
    localparam logic [1:0] MODE_CONT_MASK        = 2'b10;
    localparam int         DEFAULT_DUMMY_CYCLES  = 4;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronisers for CS, SCK and data pins plus SCK/CS edge pulses
module spi_pin_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n_pin,
    input  logic             sck_pin,
    input  logic [WIDTH-1:0] data_pin,
    output logic             cs_n,
    output logic [WIDTH-1:0] data,
    output logic             sck_rise,
    output logic             sck_fall,
    output logic             cs_fall,
    output logic             cs_rise
);
    logic [1:0]       fill;
    logic [1:0]       cs_s;
    logic [1:0]       sck_s;
    logic             cs_d;
    logic             sck_d;
    logic [WIDTH-1:0] data_s;

    // two sync stages plus one history stage; edges are suppressed until the pipeline holds real pin samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill   <= '0;
            cs_s   <= '1;
            sck_s  <= '0;
            cs_d   <= 1'b1;
            sck_d  <= 1'b0;
            data_s <= '0;
            data   <= '0;
        end else begin
            fill   <= fill + 2'(fill != 2'd3);
            cs_s   <= {cs_s[0], cs_n_pin};
            sck_s  <= {sck_s[0], sck_pin};
            cs_d   <= cs_s[1];
            sck_d  <= sck_s[1];
            data_s <= data_pin;
            data   <= data_s;
        end
    end

    // edge pulses on the synchronised levels
    always_comb begin
        cs_n     = cs_s[1];
        sck_rise = fill == 2'd3 && sck_s[1] && !sck_d;
        sck_fall = fill == 2'd3 && !sck_s[1] && sck_d;
        cs_fall  = fill == 2'd3 && !cs_s[1] && cs_d;
        cs_rise  = fill == 2'd3 && cs_s[1] && !cs_d;
    end
endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: quad-I/O NOR flash emulator answering 0xEB fast reads (with XIP) from a byte-wide memory
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int         ADDR_BITS      = 24,
    parameter int         DUMMY_CYCLES   = DEFAULT_DUMMY_CYCLES,
    parameter logic [7:0] CONT_MODE_BYTE = 8'hA0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_cs_n,
    input  logic                 spi_sck,
    input  logic [3:0]           spi_data_in,
    output logic [3:0]           spi_data_out,
    output logic [3:0]           spi_data_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data,
    output logic                 cont_mode,
    output logic                 busy,
    output logic                 cmd_error
);
    state_t               state, state_nx;
    logic                 cs_n_s, sck_rise, sck_fall, cs_fall, cs_rise;
    logic [3:0]           d;
    logic [7:0]           cnt, limit, out_byte;
    logic [ADDR_BITS-1:0] sh;
    logic                 rd_pend, last, opcode_ok, byte_done;

    spi_pin_sync #(.WIDTH(4)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n_pin (spi_cs_n),
        .sck_pin  (spi_sck),
        .data_pin (spi_data_in),
        .cs_n     (cs_n_s),
        .data     (d),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise)
    );

    // phase length per state and the rise that closes the phase
    always_comb begin
        limit     = state == CMD ? 8'd7 : state == ADDR ? 8'(ADDR_BITS/4 - 1) : state == MODE ? 8'd1 : 8'(DUMMY_CYCLES - 1);
        last      = sck_rise && cnt == limit;
        opcode_ok = {sh[6:0], d[0]} == CMD_FAST_READ_QUAD_IO;
        byte_done = state == DATA && sck_rise && cnt[0];
    end

    // next state: CS rise always aborts, otherwise advance at the end of each phase
    always_comb begin
        state_nx = state;
        if (cs_rise)
            state_nx = IDLE;
        else if (state == IDLE)
            state_nx = cs_fall ? (cont_mode ? ADDR : CMD) : IDLE;
        else if (last)
            state_nx = state == CMD ? (opcode_ok ? ADDR : IGNORE) : state == ADDR ? MODE :
                       state == MODE ? DUMMY : state == DUMMY ? DATA : state;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    // shift/count on SCK rise, prefetch one byte ahead, drive nibbles on SCK fall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            sh           <= '0;
            out_byte     <= '0;
            rd_pend      <= 1'b0;
            spi_data_out <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            cont_mode    <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            cnt     <= state_nx != state ? 8'd0 : sck_rise ? cnt + 8'd1 : cnt;
            mem_rd  <= 1'b0;
            rd_pend <= mem_rd;
            if (rd_pend)
                out_byte <= mem_data;
            if (sck_rise)
                sh <= state == CMD ? {sh[ADDR_BITS-2:0], d[0]} : {sh[ADDR_BITS-5:0], d};
            if (state == CMD && last && !opcode_ok)
                cmd_error <= 1'b1;
            if (state == ADDR && last)
                mem_addr <= {sh[ADDR_BITS-5:0], d};
            if (state == MODE && last)
                cont_mode <= sh[1:0] == CONT_MODE_BYTE[5:4];
            if ((state == DUMMY && sck_rise && cnt == 8'd0) || byte_done)
                mem_rd <= 1'b1;
            if (byte_done)
                mem_addr <= mem_addr + ADDR_BITS'(1);
            if (state == DATA && sck_fall)
                spi_data_out <= cnt[0] ? out_byte[3:0] : out_byte[7:4];
            if (cs_rise)
                spi_data_out <= '0;
        end
    end

    // pad enables only in DATA; busy while selected and active
    always_comb begin
        spi_data_oe = state == DATA ? 4'hF : 4'h0;
        busy        = !cs_n_s && state != IDLE;
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: directed QSPI initiator with scoreboarded read addresses and data nibbles
module tb_qspi_flash_responder;
    localparam int H = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs_n, spi_sck;
    logic [3:0]  spi_data_in, spi_data_out, spi_data_oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'h00;
    logic        cont_mode, busy, cmd_error;

    logic [7:0]  mem [logic [23:0]];
    logic [3:0]  exp_nib [$];
    logic [23:0] exp_addr [$];
    int          tests = 0;
    int          fails = 0;

    qspi_flash_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_sck      (spi_sck),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_data_oe  (spi_data_oe),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .cont_mode    (cont_mode),
        .busy         (busy),
        .cmd_error    (cmd_error)
    );

    always #5 clk = ~clk;

    // backing memory: data valid one clk after the read strobe
    always @(posedge clk) begin
        if (mem_rd)
            mem_data <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // read-address monitor
    always @(negedge clk) begin
        if (rst_n && mem_rd) begin
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read_addr: got read at %h expected none", mem_addr);
            end else
                check("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        end
    end

    // data-nibble monitor: the initiator samples on SCK rise while the pads are driven
    always @(posedge spi_sck) begin
        if (spi_data_oe == 4'hF) begin
            if (exp_nib.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL nibble: got %h expected none", spi_data_out);
            end else
                check("nibble", 32'(spi_data_out), 32'(exp_nib.pop_front()));
        end
    end

    task automatic sck_cycle(input logic [3:0] d, input logic [3:0] oe_exp, input bit stall);
        spi_data_in = d;
        repeat (H) @(negedge clk);
        if (stall) begin
            check("stall_start", 32'(spi_data_out), 32'(exp_nib[0]));
            repeat (1000) @(negedge clk);
            check("stall_end", 32'(spi_data_out), 32'(exp_nib[0]));
        end
        spi_sck = 1'b1;
        check("oe", 32'(spi_data_oe), 32'(oe_exp));
        repeat (H) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic xfer(input bit cmd_on, input logic [7:0] cmd, input logic [23:0] a, input logic [7:0] mode,
                        input int nb, input logic [31:0] bytes, input bit resp, input int stop,
                        input int stall, input bit keep_cs);
        int c, n, k;
        logic [3:0] d;
        c = cmd_on ? 8 : 0;
        n = c + 12 + 2 * nb;
        if (stop >= 0 && stop < n)
            n = stop;
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i < c)
                d = {3'b000, cmd[7-i]};
            else if (i < c + 6)
                d = a[23-4*(i-c) -: 4];
            else if (i < c + 8)
                d = i == c + 6 ? mode[7:4] : mode[3:0];
            else
                d = 4'h0;
            if (resp && i == c + 8)
                exp_addr.push_back(a);
            if (resp && i >= c + 12) begin
                k = i - c - 12;
                exp_nib.push_back(bytes[31-4*k -: 4]);
                if (k % 2 == 1)
                    exp_addr.push_back(a + 24'((k + 1) / 2));
            end
            sck_cycle(d, (resp && i >= c + 12) ? 4'hF : 4'h0, i == stall);
        end
        if (!keep_cs) begin
            spi_cs_n = 1'b1;
            repeat (2 * H) @(negedge clk);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data_out"}, 32'(spi_data_out), 32'h0);
        check({tag, "_oe"}, 32'(spi_data_oe), 32'h0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_cont_mode"}, 32'(cont_mode), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_cmd_error"}, 32'(cmd_error), 32'h0);
    endtask

    initial begin
        mem[24'h100000] = 8'hA9;
        mem[24'h100001] = 8'h00;
        mem[24'h100002] = 8'h85;
        mem[24'h100FFC] = 8'hC3;
        mem[24'h100FFD] = 8'h3C;
        mem[24'hFFFFFF] = 8'h7E;
        mem[24'h000000] = 8'hE7;
        rst_n       = 1'b0;
        spi_cs_n    = 1'b1;
        spi_sck     = 1'b0;
        spi_data_in = 4'h0;
        repeat (4) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // plain read: A9 00 85
        xfer(1, 8'hEB, 24'h100000, 8'h00, 3, 32'hA9008500, 1, -1, -1, 0);
        check("plain_cont_mode", 32'(cont_mode), 32'h0);
        check("plain_cmd_error", 32'(cmd_error), 32'h0);

        // continuous read: arm XIP, then a transaction without opcode, then disarm
        xfer(1, 8'hEB, 24'h100FFC, 8'hA0, 1, 32'hC3000000, 1, -1, -1, 0);
        check("xip_armed", 32'(cont_mode), 32'h1);
        xfer(0, 8'h00, 24'h100FFD, 8'h00, 1, 32'h3C000000, 1, -1, -1, 0);
        check("xip_cleared", 32'(cont_mode), 32'h0);

        // address wrap FFFFFF -> 000000
        xfer(1, 8'hEB, 24'hFFFFFF, 8'h00, 2, 32'h7EE70000, 1, -1, -1, 0);

        // unsupported opcode, then a good read
        xfer(1, 8'h03, 24'h100000, 8'h00, 1, 32'h0, 0, -1, -1, 0);
        check("bad_cmd_error", 32'(cmd_error), 32'h1);
        xfer(1, 8'hEB, 24'h100000, 8'h00, 1, 32'hA9000000, 1, -1, -1, 0);
        check("cmd_error_sticky", 32'(cmd_error), 32'h1);

        // abort after 3 address nibbles
        xfer(1, 8'hEB, 24'h123456, 8'h00, 0, 32'h0, 0, 11, -1, 1);
        check("abort_busy_before", 32'(busy), 32'h1);
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_after", 32'(busy), 32'h0);
        check("abort_oe_after", 32'(spi_data_oe), 32'h0);
        repeat (2 * H) @(negedge clk);

        // full read with a 1000-clk SCK stall before the high nibble of byte 2
        xfer(1, 8'hEB, 24'h100000, 8'h00, 3, 32'hA9008500, 1, -1, 8 + 12 + 4, 0);

        // reset mid-DATA while in XIP with CS held low
        xfer(1, 8'hEB, 24'h100FFC, 8'hA0, 1, 32'hC3000000, 1, -1, -1, 0);
        check("xip_armed2", 32'(cont_mode), 32'h1);
        xfer(0, 8'h00, 24'h100000, 8'hA0, 3, 32'hA9008500, 1, 15, -1, 1);
        check("busy_mid_data", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        xfer(1, 8'hEB, 24'h100002, 8'h00, 1, 32'h85000000, 1, -1, -1, 0);
        check("post_reset_cont_mode", 32'(cont_mode), 32'h0);
        check("post_reset_cmd_error", 32'(cmd_error), 32'h0);

        repeat (20) @(negedge clk);
        check("nibbles_left", 32'(exp_nib.size()), 32'h0);
        check("reads_left", 32'(exp_addr.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Flash-side end of the QSPI link used by the cartridge ROM path. Emulates a quad-I/O SPI NOR flash and answers Fast Read Quad I/O (0xEB) transactions, including continuous-read (XIP) mode, from a byte-wide synchronous memory port.
- Used as an in-fabric cartridge emulator on FPGA builds and as the bus-functional flash model in system benches.
- SPI pins are oversampled in the clk domain; the block does not use spi_sck as a clock.

Parameters:
- ADDR_BITS, 24, width of the flash byte address and of mem_addr.
- DUMMY_CYCLES, 4, SCK cycles between the mode byte and the first data nibble.
- CONT_MODE_BYTE, 8'hA0, mode-byte value that enables continuous-read mode (match on bits [5:4]==2'b10).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- spi_cs_n  in  1  chip select from the initiator, active-low.
- spi_sck  in  1  SPI clock from the initiator; mode 0.
- spi_data_in  in  4  SD3..SD0 from the pads.
- spi_data_out  out  4  SD3..SD0 driven toward the initiator.
- spi_data_oe  out  4  per-line output enable, 1 = drive.
- mem_addr  out  ADDR_BITS  byte address to the backing memory.
- mem_rd  out  1  one-cycle read strobe.
- mem_data  in  8  read data; valid exactly 1 clk after mem_rd.
- cont_mode  out  1  continuous-read mode is armed.
- busy  out  1  CS is asserted and the FSM is not IDLE.
- cmd_error  out  1  sticky flag: unsupported opcode received. Cleared only by reset.

Behaviour:
- Input synchronisation
  - cs_n, sck and data_in each pass through 2-flop synchronisers.
  - SCK rise/fall are detected on the synchronised signal.
  - spi_sck frequency must be ≤ clk/8.
- Reset values
  - spi_data_out=0, spi_data_oe=0, mem_rd=0, mem_addr=0, cont_mode=0, busy=0, cmd_error=0.
  - FSM in IDLE; shift registers and counters cleared.
- SCK edges
  - Sample on SCK rise.
  - Update spi_data_out on SCK fall, within 1 clk of the detected fall.
- FSM states and transitions
  - IDLE: on CS fall, go to ADDR if cont_mode=1, else CMD.
  - CMD: 8 rises, SD0 shifted MSB-first.
    - Opcode 0xEB: go to ADDR.
    - Any other opcode: set cmd_error, go to IGNORE.
  - ADDR: ADDR_BITS/4 rises, quad, MSB nibble first.
  - MODE: 2 rises, quad. At the end, cont_mode <= (mode[5:4]==2'b10).
  - DUMMY: DUMMY_CYCLES rises.
    - On the first rise, assert mem_rd for 1 clk with mem_addr = captured address.
    - mem_data is latched into the out-byte register 1 clk later.
  - DATA
    - The first fall after the last dummy rise drives the high nibble; the next fall drives the low nibble.
    - The second rise of each byte completes the byte. At that rise: mem_addr increments, mem_rd pulses, and the next byte is latched before the following fall.
    - spi_data_oe=4'hF only while in DATA; 0 in every other state.
  - IGNORE: hold outputs off until CS rises.
- Address arithmetic: mem_addr increments modulo 2^ADDR_BITS (0xFFFFFF wraps to 0).
- CS rise in any state
  - Return to IDLE within 3 clk; oe=0; busy=0; any partial byte is discarded.
  - cont_mode keeps its value.
  - CS rise before MODE completes leaves cont_mode unchanged.
- Continuous-mode exit: the initiator clocks mode ≠ 2'b10 in [5:4], or rst_n is asserted. Exiting this way makes the next transaction start in CMD.
- rst_n low mid-transaction: all state returns to reset values on the next clk, regardless of CS.
- Stalls: SCK may stop at any point with CS low, for unbounded time. The FSM holds state and the outputs hold their values.

Decomposition:
- Shared package qspi_pkg holds:
  - constants CMD_FAST_READ_QUAD_IO=8'hEB and MODE_CONT_MASK=2'b10;
  - FSM state enum {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE};
  - default DUMMY_CYCLES.
  The controller and this responder both import the package.
- One sub-module, spi_pin_sync: the 2-flop synchronisers plus SCK rise/fall and CS fall/rise pulse generation, parameterised by width.

Test Plan:
- Plain read. Reset, then CS low, send 0xEB, address 0x100000, mode 0x00, 4 dummy cycles, 3 data bytes; mem holds 0x100000=0xA9, 0x100001=0x00, 0x100002=0x85.
  - SD returns nibbles A,9,0,0,8,5.
  - mem_rd pulses at 0x100000, 0x100001, 0x100002 (and prefetch 0x100003).
  - oe=F only during data; cont_mode stays 0.
- Continuous read. Mode 0xA0 at address 0x100FFC, then CS high. Next transaction sends address 0x100FFD with no opcode.
  - cont_mode=1 after the first transaction.
  - The second transaction returns the byte at 0x100FFD.
  - Sending mode 0x00 in the second transaction clears cont_mode.
- Address wrap. Address 0xFFFFFF, read 2 bytes -> mem_addr sequence FFFFFF then 000000; data matches mem.
- Bad opcode. Send 0x03 -> cmd_error=1 and oe stays 0 through CS high. A following valid 0xEB read succeeds, and cmd_error remains 1.
- Abort and stall.
  - CS high after 3 address nibbles -> IDLE and busy=0 within 3 clk; the next full read returns correct data.
  - Holding SCK low for 1000 clk mid-DATA -> spi_data_out stable, then resumes with the correct nibble.
- Reset mid-DATA. Pull rst_n low for 1 clk with CS still low -> all outputs reach reset values on the next clk and cont_mode=0. After CS toggles, the responder expects an opcode.
